seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: settles each multiplexed digit, gathers positions into a
// shadow frame and publishes complete 8-digit frames with stability and timeout status.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg7_sel,
    input  logic [7:0]  seg7,
    output logic [39:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  illegal,
    output logic        frame_valid,
    output logic        stable,
    output logic        sel_err,
    output logic        scan_lost,
    output logic [7:0]  frame_cnt
);

    // state     | meaning
    // S_IDLE    | no capture since reset or since scan_lost
    // S_COLLECT | gathering positions into the shadow frame
    // S_PUBLISH | shadow frame was just copied to the outputs
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUBLISH} state_t;

    localparam int unsigned   IW         = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    SETTLE_C   = 4'(SETTLE);
    localparam logic [IW-1:0] TIMEOUT_C  = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_ONE   = IW'(1);
    localparam logic [4:0]    CODE_BLANK = 5'd16;
    localparam logic [4:0]    CODE_BAD   = 5'd31;

    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode = 5'd0;
            7'h06:   decode = 5'd1;
            7'h5B:   decode = 5'd2;
            7'h4F:   decode = 5'd3;
            7'h66:   decode = 5'd4;
            7'h6D:   decode = 5'd5;
            7'h7D:   decode = 5'd6;
            7'h07:   decode = 5'd7;
            7'h7F:   decode = 5'd8;
            7'h6F:   decode = 5'd9;
            7'h77:   decode = 5'd10;
            7'h7C:   decode = 5'd11;
            7'h39:   decode = 5'd12;
            7'h5E:   decode = 5'd13;
            7'h79:   decode = 5'd14;
            7'h71:   decode = 5'd15;
            7'h00:   decode = 5'd16;
            7'h40:   decode = 5'd17;
            default: decode = CODE_BAD;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      sel_q, seg_q;
    logic [15:0]     prev_q;
    logic [3:0]      settle_q, settle_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [7:0]      seen_q, seen_d;
    logic [7:0][4:0] shadow_code_q, shadow_code_d;
    logic [7:0]      shadow_dp_q, shadow_dp_d;
    logic [7:0]      shadow_ill_q, shadow_ill_d;
    logic [7:0][4:0] digits_q, digits_d;
    logic [7:0]      dp_q, dp_d;
    logic [7:0]      illegal_q, illegal_d;
    logic            frame_valid_q, frame_valid_d;
    logic            stable_q, stable_d;
    logic            sel_err_q, sel_err_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    logic [15:0]     cur;
    logic            same, hit, sel_onehot, capture, lost_rise, publish;
    logic [4:0]      code;

    always_comb begin
        cur        = {sel_q, seg_q};
        same       = (cur == prev_q);
        code       = decode(seg_q[6:0]);
        sel_onehot = (sel_q != 8'd0) && ((sel_q & (sel_q - 8'd1)) == 8'd0);

        if (!same)                     settle_d = 4'd1;
        else if (settle_q >= SETTLE_C) settle_d = SETTLE_C;
        else                           settle_d = settle_q + 4'd1;

        // a change re-arms capture even when SETTLE is 1 and the counter never moves
        hit       = (settle_d == SETTLE_C) && (!same || (settle_q != SETTLE_C));
        capture   = hit && sel_onehot;
        sel_err_d = hit && !sel_onehot && (sel_q != 8'd0);

        if (capture)                 idle_d = '0;
        else if (idle_q == TIMEOUT_C) idle_d = idle_q;
        else                          idle_d = idle_q + IDLE_ONE;
        lost_rise = (idle_d == TIMEOUT_C) && (idle_q != TIMEOUT_C);

        state_d = state_q;
        publish = 1'b0;
        case (state_q)
            S_IDLE:    if (capture) state_d = S_COLLECT;
            S_COLLECT: if (seen_q == 8'hFF) begin
                state_d = S_PUBLISH;
                publish = 1'b1;
            end
            S_PUBLISH: state_d = S_COLLECT;
            default:   state_d = S_IDLE;
        endcase
        if (lost_rise) state_d = S_IDLE;

        seen_d        = (publish || lost_rise) ? 8'd0 : seen_q;
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_ill_d  = shadow_ill_q;
        for (int i = 0; i < 8; i++) begin
            if (capture && sel_q[i]) begin
                shadow_code_d[i] = code;
                shadow_dp_d[i]   = seg_q[7];
                shadow_ill_d[i]  = (code == CODE_BAD);
                seen_d[i]        = 1'b1;
            end
        end

        digits_d      = digits_q;
        dp_d          = dp_q;
        illegal_d     = illegal_q;
        stable_d      = stable_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = publish;
        if (publish) begin
            stable_d    = (shadow_code_q == digits_q) && (shadow_dp_q == dp_q);
            digits_d    = shadow_code_q;
            dp_d        = shadow_dp_q;
            illegal_d   = shadow_ill_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            seg_q         <= '0;
            prev_q        <= '0;
            settle_q      <= '0;
            idle_q        <= '0;
            seen_q        <= '0;
            shadow_code_q <= {8{CODE_BLANK}};
            shadow_dp_q   <= '0;
            shadow_ill_q  <= '0;
            digits_q      <= {8{CODE_BLANK}};
            dp_q          <= '0;
            illegal_q     <= '0;
            frame_valid_q <= 1'b0;
            stable_q      <= 1'b0;
            sel_err_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= seg7_sel;
            seg_q         <= seg7;
            prev_q        <= cur;
            settle_q      <= settle_d;
            idle_q        <= idle_d;
            seen_q        <= seen_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_ill_q  <= shadow_ill_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            illegal_q     <= illegal_d;
            frame_valid_q <= frame_valid_d;
            stable_q      <= stable_d;
            sel_err_q     <= sel_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign illegal     = illegal_q;
    assign frame_valid = frame_valid_q;
    assign stable      = stable_q;
    assign sel_err     = sel_err_q;
    assign scan_lost   = (idle_q == TIMEOUT_C);
    assign frame_cnt   = frame_cnt_q;

endmodule
